downstream_adp: RTL and testbench
=================================

// Module: downstream_adp
// PURPOSE
//  AXI-stream receiver; inverse of the upstream adaptor. Accepts one packet (event) per buffer
//  and writes it into a GEP-style event buffer. Word 0 is the header, holding the top pointer
//  and TID. Data words go to addresses 1..top. Signals buffer-complete through the EvTID
//  ready/done handshake.
// PARAMETERS
//  ADDR_WIDTH  10  buffer address width; data addr max = 2**ADDR_WIDTH-1; legal range 2..116
// PORTS
//  clk            in   1    clock (only clock)
//  ARESETn        in   1    reset, asynchronous, active-low
//  TVALID         in   1    AXI-S beat valid
//  TREADY         out  1    AXI-S ready (registered)
//  TDATA          in   128  beat data
//  TSTRB, TKEEP   in   16   byte qualifiers; byte enable = TKEEP & TSTRB
//  TLAST          in   1    last beat of packet
//  TID            in   11   event/BCID, sampled on first beat only
//  wr_en          out  1    buffer write strobe (registered)
//  wr_addr        out  AW   buffer write address (registered)
//  wr_data        out  128  buffer write data (registered)
//  wr_be          out  16   buffer byte enables (registered)
//  wr_EvTID_ready in   1    empty buffer available for writing
//  wr_EvTID_DONE  out  1    1-cycle pulse: buffer complete, header written
//  pkt_ovf        out  1    1-cycle pulse, coincident with DONE: packet was truncated
// BEHAVIOUR
//  Reset: all outputs are 0, state IDLE, addr=1, ovf=0, tid_q=0.
//  Reset mid-packet abandons the partial packet. No header is written and no DONE is issued.
//  ready_q = wr_EvTID_ready & ~wr_EvTID_DONE. Done masks ready for one cycle, as upstream does.
//  FSM:
//   IDLE: TREADY=0, wr_en=0. On ready_q go to RECV; TREADY=1 from the next cycle. addr=1.
//   RECV: TREADY=1. Beat accepted on edge when TVALID&TREADY.
//     On acceptance, the next cycle shows wr_en=1, wr_addr=addr, wr_data=TDATA,
//     and wr_be=TKEEP&TSTRB. Write latency is 1 cycle.
//     First accepted beat latches TID into tid_q. TID on later beats is ignored.
//     addr increments per accepted beat; top_q <= addr.
//     When addr == 2**AW-1 and a beat is accepted without TLAST, set ovf (sticky) and stop
//     incrementing. Further beats are accepted (TREADY stays 1) and dropped (wr_en=0).
//     Beat with TLAST accepted: go to HDR and drop TREADY on the next cycle.
//     With TVALID=0, hold state and write nothing.
//   HDR:  TREADY=0. On the next cycle: wr_en=1, wr_addr=0, wr_be=16'hffff, and
//     wr_data = {ovf, 0..., tid_q at [AW+10:AW], top_q at [AW-1:0]}. Go to DONE.
//   DONE: TREADY=0, wr_en=0. wr_EvTID_DONE=1 and pkt_ovf=ovf for exactly this cycle.
//     Clear ovf and go to IDLE. DONE is always at least 1 cycle after the header write.
//  Single-beat packet: top=1. A max-length packet (2**AW-1 beats, TLAST on the last) has top=2**AW-1 and ovf=0.
//  Minimum gap between packets is 3 cycles after the TLAST beat (HDR, DONE, masked IDLE).
//  wr_EvTID_ready dropping during RECV is ignored. The packet completes normally.
//  TVALID with TREADY=0: the beat is not consumed. AXI requires the source to hold it stable.
// TESTING
//  1 Ready=1, 4 beats D1..D4 (TLAST on D4), TID=8:
//    writes addr1..4=D1..D4, then addr0 hdr top=4 TID=8 at [20:10], one DONE pulse, pkt_ovf=0.
//  2 Single beat with TLAST, TKEEP=16'h00ff, TSTRB=16'hffff:
//    addr1 written with be=16'h00ff; hdr top=1; DONE one cycle after the hdr write.
//  3 Random TVALID gaps and ready-holding source: no duplicate or missing writes, addresses
//    contiguous, TDATA order preserved, hdr top equals the beat count.
//  4 ADDR_WIDTH=3, 10-beat packet: addr1..7 written, beats 8..10 dropped,
//    hdr top=7 with bit127=1, pkt_ovf pulses with DONE.
//  5 Ready held high, back-to-back packets: TREADY low for exactly 3 cycles between packets;
//    second packet's TID is sampled from its own first beat.
//  6 ARESETn asserted async mid-RECV after 2 beats: outputs go to 0 immediately, no hdr or
//    DONE; after release the next packet starts at addr1.

Source files
------------

// File: rtl/downstream_adp.sv
// downstream_adp: AXI-stream receiver that writes one packet per event buffer.
// Data beats land at addresses 1..top. The header at address 0 carries the overflow
// flag, the TID and the top pointer. Buffer completion is reported on the EvTID
// ready/done handshake.
module downstream_adp #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  ARESETn,
  input  logic                  TVALID,
  output logic                  TREADY,
  input  logic [127:0]          TDATA,
  input  logic [15:0]           TSTRB,
  input  logic [15:0]           TKEEP,
  input  logic                  TLAST,
  input  logic [10:0]           TID,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [127:0]          wr_data,
  output logic [15:0]           wr_be,
  input  logic                  wr_EvTID_ready,
  output logic                  wr_EvTID_DONE,
  output logic                  pkt_ovf
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_HDR, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            ready_q;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   top_q, top_d;
  logic            ovf_q, ovf_d;
  logic [10:0]     tid_q, tid_d;
  logic            tready_d, wr_en_d, done_d, povf_d;
  logic [AW-1:0]   wr_addr_d;
  logic [127:0]    wr_data_d, hdr;
  logic [15:0]     wr_be_d;
  logic            acc, keep_beat;

  // TREADY is only ever high in RECV, so this is the AXI handshake.
  assign acc       = (state_q == S_RECV) & TVALID & TREADY;
  // Beats after an overflow are consumed but never written.
  assign keep_beat = acc & ~ovf_q;

  // Buffer-available flag, masked for one cycle by our own DONE pulse.
  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) ready_q <= 1'b0;
    else          ready_q <= wr_EvTID_ready & ~wr_EvTID_DONE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic; a drop of wr_EvTID_ready during RECV is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ready_q) state_d = S_RECV;
      S_RECV:  if (acc && TLAST) state_d = S_HDR;
      S_HDR:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Header word: overflow in the MSB, TID above the top pointer.
  always_comb begin
    hdr               = '0;
    hdr[127]          = ovf_q;
    hdr[AW+10:AW]     = tid_q;
    hdr[AW-1:0]       = top_q;
  end

  // FSM outputs, computed one cycle ahead so every port is a flop.
  always_comb begin
    tready_d  = (state_d == S_RECV);
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_be_d   = '0;
    if (keep_beat) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = TDATA;
      wr_be_d   = TKEEP & TSTRB;
    end else if (state_q == S_HDR) begin
      wr_en_d   = 1'b1;
      wr_addr_d = '0;
      wr_data_d = hdr;
      wr_be_d   = 16'hffff;
    end
    // DONE lands the cycle after the header write.
    done_d = (state_q == S_DONE);
    povf_d = (state_q == S_DONE) & ovf_q;
  end

  // Packet bookkeeping: address, top pointer, sticky overflow, first-beat TID.
  always_comb begin
    addr_d = addr_q;
    top_d  = top_q;
    ovf_d  = ovf_q;
    tid_d  = tid_q;
    case (state_q)
      S_IDLE: addr_d = ADDR_ONE;
      S_RECV: if (keep_beat) begin
        // addr 1 only occurs before the first accepted beat.
        if (addr_q == ADDR_ONE) tid_d = TID;
        top_d = addr_q;
        if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_ONE;
        else if (!TLAST)        ovf_d  = 1'b1;
      end
      S_DONE: begin
        ovf_d  = 1'b0;
        addr_d = ADDR_ONE;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q        <= ADDR_ONE;
      top_q         <= '0;
      ovf_q         <= 1'b0;
      tid_q         <= '0;
      TREADY        <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_be         <= '0;
      wr_EvTID_DONE <= 1'b0;
      pkt_ovf       <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      top_q         <= top_d;
      ovf_q         <= ovf_d;
      tid_q         <= tid_d;
      TREADY        <= tready_d;
      wr_en         <= wr_en_d;
      wr_addr       <= wr_addr_d;
      wr_data       <= wr_data_d;
      wr_be         <= wr_be_d;
      wr_EvTID_DONE <= done_d;
      pkt_ovf       <= povf_d;
    end
  end

endmodule

// File: tb/tb_downstream_adp.sv
// tb_downstream_adp: directed bench for downstream_adp. Two instances share the stream:
// ADDR_WIDTH=10 for the normal cases and ADDR_WIDTH=3 for overflow and full-buffer cases.
module tb_downstream_adp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         ARESETn, TVALID, TLAST, wr_EvTID_ready;
  logic [127:0] TDATA;
  logic [15:0]  TSTRB, TKEEP;
  logic [10:0]  TID;

  logic         a_tready, a_en, a_done, a_ovf;
  logic [9:0]   a_addr;
  logic [127:0] a_data;
  logic [15:0]  a_be;
  logic         b_tready, b_en, b_done, b_ovf;
  logic [2:0]   b_addr;
  logic [127:0] b_data;
  logic [15:0]  b_be;

  downstream_adp #(.ADDR_WIDTH(10)) u_dut (
    .clk(clk), .ARESETn(ARESETn), .TVALID(TVALID), .TREADY(a_tready), .TDATA(TDATA),
    .TSTRB(TSTRB), .TKEEP(TKEEP), .TLAST(TLAST), .TID(TID), .wr_en(a_en),
    .wr_addr(a_addr), .wr_data(a_data), .wr_be(a_be), .wr_EvTID_ready(wr_EvTID_ready),
    .wr_EvTID_DONE(a_done), .pkt_ovf(a_ovf));

  downstream_adp #(.ADDR_WIDTH(3)) u_dut3 (
    .clk(clk), .ARESETn(ARESETn), .TVALID(TVALID), .TREADY(b_tready), .TDATA(TDATA),
    .TSTRB(TSTRB), .TKEEP(TKEEP), .TLAST(TLAST), .TID(TID), .wr_en(b_en),
    .wr_addr(b_addr), .wr_data(b_data), .wr_be(b_be), .wr_EvTID_ready(wr_EvTID_ready),
    .wr_EvTID_DONE(b_done), .pkt_ovf(b_ovf));

  typedef struct {
    int           addr;
    logic [127:0] data;
    logic [15:0]  be;
    int           cyc;
  } wr_t;

  wr_t aq[$], bq[$];
  wr_t mw;
  int  gapq[$];
  int  cyc = 0, lowrun = 0, trdy_mis = 0;
  int  a_dones = 0, a_done_cyc = 0, a_ovfs = 0;
  int  b_dones = 0, b_ovf_done = 0, b_ovf_lone = 0;
  int  nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write/DONE logger, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (a_en) begin
      mw.addr = int'(a_addr); mw.data = a_data; mw.be = a_be; mw.cyc = cyc;
      aq.push_back(mw);
    end
    if (a_done) begin a_dones++; a_done_cyc = cyc; end
    if (a_ovf) a_ovfs++;
    if (b_en) begin
      mw.addr = int'(b_addr); mw.data = b_data; mw.be = b_be; mw.cyc = cyc;
      bq.push_back(mw);
    end
    if (b_done) begin b_dones++; if (b_ovf) b_ovf_done++; end
    if (b_ovf && !b_done) b_ovf_lone++;
    if (a_tready !== b_tready) trdy_mis++;
    if (!a_tready) lowrun++;
    else begin
      if (lowrun > 0) gapq.push_back(lowrun);
      lowrun = 0;
    end
  end

  task automatic clr();
    aq.delete(); bq.delete(); gapq.delete();
    lowrun = 0; a_dones = 0; a_ovfs = 0; b_dones = 0; b_ovf_done = 0; b_ovf_lone = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted.
  task automatic beat(input logic [127:0] d, input logic [15:0] k, input logic [15:0] s,
                      input logic l, input logic [10:0] t);
    int n;
    TVALID = 1'b1; TDATA = d; TKEEP = k; TSTRB = s; TLAST = l; TID = t;
    n = 0;
    @(negedge clk);
    while (!a_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("tready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // nb-beat packet with data base+1..base+nb; TID valid only on the first beat.
  task automatic send(input int nb, input logic [10:0] tid, input logic [127:0] base);
    for (int i = 0; i < nb; i++)
      beat(base + 128'(i + 1), 16'hffff, 16'hffff, (i == nb - 1), (i == 0) ? tid : 11'h7ff);
  endtask

  task automatic idle();
    TVALID = 1'b0; TLAST = 1'b0;
  endtask

  int gaps[6] = '{0, 2, 1, 3, 0, 1};

  initial begin
    ARESETn = 1'b0; TVALID = 1'b0; TLAST = 1'b0; TDATA = '0; TKEEP = '0; TSTRB = '0;
    TID = '0; wr_EvTID_ready = 1'b0;
    wait_cyc(3);
    chk("rst_ctl", {a_tready, a_en, a_done, a_ovf}, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_data", a_data, 0);
    chk("rst_be", a_be, 0);
    @(negedge clk); ARESETn = 1'b1;
    wait_cyc(3);
    chk("idle_no_buffer_tready", a_tready, 0);
    wr_EvTID_ready = 1'b1;
    wait_cyc(4);
    chk("recv_tready", a_tready, 1);

    // 1: four beats, TID 8
    clr();
    send(4, 11'd8, 128'hD0); idle(); wait_cyc(8);
    chk("t1_nwr", aq.size(), 5);
    if (aq.size() == 5) begin
      for (int k = 0; k < 4; k++) begin
        chk("t1_addr", aq[k].addr, k + 1);
        chk("t1_data", aq[k].data, 128'hD1 + 128'(k));
      end
      chk("t1_hdr_addr", aq[4].addr, 0);
      chk("t1_hdr_data", aq[4].data, 128'h2004);
      chk("t1_hdr_be", aq[4].be, 16'hffff);
      chk("t1_done_lag", a_done_cyc - aq[4].cyc, 1);
    end
    chk("t1_dones", a_dones, 1);
    chk("t1_ovf", a_ovfs, 0);

    // 2: single beat, partial byte enables
    clr();
    beat(128'hABCD, 16'h00ff, 16'hffff, 1'b1, 11'd3); idle(); wait_cyc(8);
    chk("t2_nwr", aq.size(), 2);
    if (aq.size() == 2) begin
      chk("t2_addr", aq[0].addr, 1);
      chk("t2_be", aq[0].be, 16'h00ff);
      chk("t2_data", aq[0].data, 128'hABCD);
      chk("t2_hdr", aq[1].data, 128'hC01);
      chk("t2_done_lag", a_done_cyc - aq[1].cyc, 1);
    end
    chk("t2_dones", a_dones, 1);

    // 3: TVALID gaps between beats
    clr();
    for (int i = 0; i < 6; i++) begin
      if (gaps[i] > 0) begin idle(); wait_cyc(gaps[i]); end
      beat(128'h300 + 128'(i + 1), 16'hffff, 16'hffff, (i == 5), (i == 0) ? 11'd6 : 11'h7ff);
    end
    idle(); wait_cyc(8);
    chk("t3_nwr", aq.size(), 7);
    if (aq.size() == 7) begin
      for (int k = 0; k < 6; k++) begin
        chk("t3_addr", aq[k].addr, k + 1);
        chk("t3_data", aq[k].data, 128'h301 + 128'(k));
      end
      chk("t3_hdr", aq[6].data, 128'h1806);
    end

    // 4: overflow on the 3-bit instance, 10 beats
    clr();
    send(10, 11'd5, 128'h400); idle(); wait_cyc(8);
    chk("t4_nwr", bq.size(), 8);
    if (bq.size() == 8) begin
      for (int k = 0; k < 7; k++) begin
        chk("t4_addr", bq[k].addr, k + 1);
        chk("t4_data", bq[k].data, 128'h401 + 128'(k));
      end
      chk("t4_hdr_addr", bq[7].addr, 0);
      chk("t4_hdr", bq[7].data, {1'b1, 127'h2F});
    end
    chk("t4_ovf_with_done", b_ovf_done, 1);
    chk("t4_ovf_alone", b_ovf_lone, 0);
    chk("t4_dones", b_dones, 1);
    chk("t4_wide_nwr", aq.size(), 11);
    if (aq.size() == 11) chk("t4_wide_hdr", aq[10].data, 128'h140A);
    chk("t4_wide_ovf", a_ovfs, 0);

    // 4b: exactly full 3-bit buffer, no overflow
    clr();
    send(7, 11'd2, 128'h500); idle(); wait_cyc(8);
    chk("t4b_nwr", bq.size(), 8);
    if (bq.size() == 8) chk("t4b_hdr", bq[7].data, 128'h17);
    chk("t4b_ovf", b_ovf_done, 0);

    // 5: back-to-back packets with TVALID held
    clr();
    send(2, 11'd1, 128'h600);
    send(2, 11'd2, 128'h700);
    idle(); wait_cyc(10);
    chk("t5_gap_seen", gapq.size() > 0, 1);
    if (gapq.size() > 0) chk("t5_gap", gapq[0], 3);
    chk("t5_nwr", aq.size(), 6);
    if (aq.size() == 6) begin
      chk("t5_hdr_a", aq[2].data, 128'h402);
      chk("t5_b_addr", aq[3].addr, 1);
      chk("t5_b_data", aq[3].data, 128'h701);
      chk("t5_hdr_b", aq[5].data, 128'h802);
    end

    // 6: asynchronous reset after two beats
    beat(128'h801, 16'hffff, 16'hffff, 1'b0, 11'd9);
    beat(128'h802, 16'hffff, 16'hffff, 1'b0, 11'h7ff);
    @(negedge clk);
    #2 ARESETn = 1'b0;
    #1;
    chk("t6_rst_en", a_en, 0);
    chk("t6_rst_tready", a_tready, 0);
    chk("t6_rst_addr", a_addr, 0);
    idle();
    clr();
    wait_cyc(3);
    @(negedge clk); ARESETn = 1'b1;
    wait_cyc(5);
    chk("t6_no_hdr", aq.size(), 0);
    chk("t6_no_done", a_dones, 0);
    send(1, 11'd4, 128'h900); idle(); wait_cyc(8);
    chk("t6_nwr", aq.size(), 2);
    if (aq.size() == 2) begin
      chk("t6_addr", aq[0].addr, 1);
      chk("t6_data", aq[0].data, 128'h901);
      chk("t6_hdr", aq[1].data, 128'h1001);
    end

    chk("tready_agree", trdy_mis, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
